// File: rtl/la_ioshort_ctrl.sv
// -----------------------------------------------------------------------------
// la_ioshort_ctrl
//
// Break-before-make direction sequencer for a bank of N la_ioshort cells.
// One direction-change request is taken at a time over a valid/ready
// handshake. A real change raises iso for the target channel, holds it for
// TURN cycles, flips that channel's a2b, holds iso for SETTLE more cycles and
// then releases it. The requester sees a one-cycle done pulse when it is over.
//
// Ports:
//   clk        clock
//   nreset     asynchronous active-low reset
//   req_valid  request valid
//   req_sel    target channel index (values >= N are rejected with err)
//   req_dir    requested a2b value (1 = a drives b)
//   req_ready  controller idle, a request is accepted on this edge
//   a2b[N]     per-channel direction to the short cells
//   iso[N]     per-channel isolation, high = pad/core drivers tristated
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done when the request was rejected
//   busy       high while a transition is in progress
// -----------------------------------------------------------------------------
module la_ioshort_ctrl #(
    parameter int   N        = 4,
    parameter int   TURN     = 2,
    parameter int   SETTLE   = 2,
    parameter logic RESETDIR = 1'b0,
    // Select width may be widened so out-of-range indices can be presented.
    parameter int   SELW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            req_valid,
    input  logic [SELW-1:0] req_sel,
    input  logic            req_dir,
    output logic            req_ready,
    output logic [N-1:0]    a2b,
    output logic [N-1:0]    iso,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int MAXC = (TURN > SETTLE) ? TURN : SETTLE;
    localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISO    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [N-1:0]    sel_q,   sel_d;    // one-hot channel being changed
    logic            dir_q,   dir_d;
    logic [N-1:0]    a2b_q,   a2b_d;
    logic [N-1:0]    iso_q,   iso_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;
    logic            busy_q,  busy_d;

    // One-hot decode of the incoming select; an all-zero result means the
    // index is outside the bank.
    logic [N-1:0]    req_hit;
    logic            req_in_range;
    logic            req_cur_dir;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel_dec
            assign req_hit[gi] = (req_sel == SELW'(gi));
        end
    endgenerate

    assign req_in_range = |req_hit;
    assign req_cur_dir  = |(req_hit & a2b_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        a2b_d   = a2b_q;
        iso_d   = iso_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_in_range) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (req_dir == req_cur_dir) begin
                        // Already in the requested direction: nothing to do.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ISO;
                        cnt_d   = CW'(TURN - 1);
                        sel_d   = req_hit;
                        dir_d   = req_dir;
                        iso_d   = req_hit;
                    end
                end
            end
            ST_ISO: begin
                if (cnt_q == '0) begin
                    // Drivers have been isolated for TURN cycles; flip only
                    // the selected channel.
                    a2b_d   = (a2b_q & ~sel_q) | ({N{dir_q}} & sel_q);
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(SETTLE - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    iso_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                iso_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            a2b_q   <= {N{RESETDIR}};
            iso_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            a2b_q   <= a2b_d;
            iso_q   <= iso_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign a2b       = a2b_q;
    assign iso       = iso_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
